// File: rtl/sap1_ctrl_pkg.sv
// Package : sap1_ctrl_pkg
// Purpose : Shared constants for the SAP-1 control path. It holds the
//           opcode encodings, the control-word bit indices and masks,
//           the micro-step numbers T0..T4 and the decode result bundle.
//           The IR, the ALU and the benches use the same definitions.
// Ports   : none (package)
package sap1_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 16;
    localparam int STEP_W   = 3;

    // Opcodes (upper nibble of the instruction register)
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // Control-word bit positions
    localparam int B_HLT = 0;
    localparam int B_MI  = 1;
    localparam int B_RI  = 2;
    localparam int B_RO  = 3;
    localparam int B_IO  = 4;
    localparam int B_II  = 5;
    localparam int B_AI  = 6;
    localparam int B_AO  = 7;
    localparam int B_EO  = 8;
    localparam int B_SU  = 9;
    localparam int B_BI  = 10;
    localparam int B_OI  = 11;
    localparam int B_CE  = 12;
    localparam int B_CO  = 13;
    localparam int B_J   = 14;
    localparam int B_FI  = 15;

    // One-hot masks for the bit positions above
    localparam logic [CTRL_W-1:0] C_NONE = 16'h0000;
    localparam logic [CTRL_W-1:0] C_HLT  = 16'h0001;
    localparam logic [CTRL_W-1:0] C_MI   = 16'h0002;
    localparam logic [CTRL_W-1:0] C_RI   = 16'h0004;
    localparam logic [CTRL_W-1:0] C_RO   = 16'h0008;
    localparam logic [CTRL_W-1:0] C_IO   = 16'h0010;
    localparam logic [CTRL_W-1:0] C_II   = 16'h0020;
    localparam logic [CTRL_W-1:0] C_AI   = 16'h0040;
    localparam logic [CTRL_W-1:0] C_AO   = 16'h0080;
    localparam logic [CTRL_W-1:0] C_EO   = 16'h0100;
    localparam logic [CTRL_W-1:0] C_SU   = 16'h0200;
    localparam logic [CTRL_W-1:0] C_BI   = 16'h0400;
    localparam logic [CTRL_W-1:0] C_OI   = 16'h0800;
    localparam logic [CTRL_W-1:0] C_CE   = 16'h1000;
    localparam logic [CTRL_W-1:0] C_CO   = 16'h2000;
    localparam logic [CTRL_W-1:0] C_J    = 16'h4000;
    localparam logic [CTRL_W-1:0] C_FI   = 16'h8000;

    // Micro-step numbers
    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    // Decoder result: control word plus "this is the final step"
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              last;
    } decode_t;

    // True when a control word drives the bus from more than one source
    function automatic logic multi_driver(input logic [CTRL_W-1:0] w);
        int n;
        n = 0;
        if (w[B_CO]) n++;
        if (w[B_RO]) n++;
        if (w[B_IO]) n++;
        if (w[B_AO]) n++;
        if (w[B_EO]) n++;
        return n > 1;
    endfunction

endpackage

// File: rtl/step_counter.sv
// Module : step_counter
// Purpose: Micro-step counter with synchronous clear, an advance qualifier,
//          a freeze input (used while halting) and a wrap-to-zero input
//          taken at the final step of each instruction.
// Ports  : clk, reset (sync, active-high), enable (advance qualifier),
//          freeze (hold regardless of enable), wrap (next step is 0),
//          step (current step value)
module step_counter
    import sap1_ctrl_pkg::*;
#(
    parameter int WIDTH = STEP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             wrap,
    output logic [WIDTH-1:0] step
);

    always_ff @(posedge clk) begin
        if (reset) begin
            step <= '0;
        end else if (enable && !freeze) begin
            if (wrap) begin
                step <= '0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Module : control_sequencer
// Purpose: SAP-1 micro-step controller. It runs a two-step fetch (T0, T1)
//          and then up to three execute steps decoded from the opcode and
//          flags. It drives the control word for every bus participant and
//          is the only source of the PC count/load/halt signals.
// Ports  : mclk (clock), i_reset (sync active-high), mclk_en (step
//          qualifier), i_opcode (IR upper nibble), i_carry_flag and
//          i_zero_flag (registered ALU flags), o_ctrl (control word for the
//          current step), o_step (current micro-step), o_halted (sticky halt)
module control_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int CTRL_WIDTH   = CTRL_W,
    parameter int STEP_WIDTH   = STEP_W
) (
    input  logic                    mclk,
    input  logic                    i_reset,
    input  logic                    mclk_en,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_carry_flag,
    input  logic                    i_zero_flag,
    output logic [CTRL_WIDTH-1:0]   o_ctrl,
    output logic [STEP_WIDTH-1:0]   o_step,
    output logic                    o_halted
);

    logic [STEP_W-1:0] step;
    logic              halted;
    logic              halt_now;
    decode_t           dec;

    // Decode on {step, opcode}. Flags only matter in T2 of JC/JZ.
    // Any step/opcode combination not listed ends the instruction with
    // an empty control word, so unused opcodes behave as NOP.
    always_comb begin
        dec.ctrl = C_NONE;
        dec.last = 1'b0;
        casez ({step, i_opcode})
            {T0, 4'b????}: begin
                dec.ctrl = C_CO | C_MI;
            end
            {T1, 4'b????}: begin
                dec.ctrl = C_RO | C_II | C_CE;
            end
            {T2, OP_LDA},
            {T2, OP_ADD},
            {T2, OP_SUB},
            {T2, OP_STA}: begin
                dec.ctrl = C_IO | C_MI;
            end
            {T2, OP_LDI}: begin
                dec.ctrl = C_IO | C_AI;
                dec.last = 1'b1;
            end
            {T2, OP_JMP}: begin
                dec.ctrl = C_IO | C_J;
                dec.last = 1'b1;
            end
            {T2, OP_JC}: begin
                dec.ctrl = i_carry_flag ? (C_IO | C_J) : C_NONE;
                dec.last = 1'b1;
            end
            {T2, OP_JZ}: begin
                dec.ctrl = i_zero_flag ? (C_IO | C_J) : C_NONE;
                dec.last = 1'b1;
            end
            {T2, OP_OUT}: begin
                dec.ctrl = C_AO | C_OI;
                dec.last = 1'b1;
            end
            {T2, OP_HLT}: begin
                // Step freezes here instead of wrapping.
                dec.ctrl = C_HLT;
            end
            {T3, OP_LDA}: begin
                dec.ctrl = C_RO | C_AI;
                dec.last = 1'b1;
            end
            {T3, OP_ADD},
            {T3, OP_SUB}: begin
                dec.ctrl = C_RO | C_BI;
            end
            {T3, OP_STA}: begin
                dec.ctrl = C_AO | C_RI;
                dec.last = 1'b1;
            end
            {T4, OP_ADD}: begin
                dec.ctrl = C_EO | C_AI | C_FI;
                dec.last = 1'b1;
            end
            {T4, OP_SUB}: begin
                dec.ctrl = C_EO | C_AI | C_FI | C_SU;
                dec.last = 1'b1;
            end
            default: begin
                dec.ctrl = C_NONE;
                dec.last = 1'b1;
            end
        endcase
    end

    assign halt_now = (step == T2) && (i_opcode == OP_HLT) && !halted;

    always_ff @(posedge mclk) begin
        if (i_reset) begin
            halted <= 1'b0;
        end else if (mclk_en && halt_now) begin
            halted <= 1'b1;
        end
    end

    step_counter #(
        .WIDTH (STEP_W)
    ) u_step (
        .clk    (mclk),
        .reset  (i_reset),
        .enable (mclk_en),
        .freeze (halted | halt_now),
        .wrap   (dec.last),
        .step   (step)
    );

    // Once halted the decode is masked so only HLT reaches the bus.
    assign o_ctrl   = halted ? C_HLT : dec.ctrl;
    assign o_step   = step;
    assign o_halted = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench  : tb_control_sequencer
// Purpose: vector table, directed corner sequences and a random run
//          against an instruction-level model of control_sequencer.
module tb_control_sequencer;

    localparam logic [15:0] K_HLT = 16'h0001;
    localparam logic [15:0] K_MI  = 16'h0002;
    localparam logic [15:0] K_RI  = 16'h0004;
    localparam logic [15:0] K_RO  = 16'h0008;
    localparam logic [15:0] K_IO  = 16'h0010;
    localparam logic [15:0] K_II  = 16'h0020;
    localparam logic [15:0] K_AI  = 16'h0040;
    localparam logic [15:0] K_AO  = 16'h0080;
    localparam logic [15:0] K_EO  = 16'h0100;
    localparam logic [15:0] K_SU  = 16'h0200;
    localparam logic [15:0] K_BI  = 16'h0400;
    localparam logic [15:0] K_OI  = 16'h0800;
    localparam logic [15:0] K_CE  = 16'h1000;
    localparam logic [15:0] K_CO  = 16'h2000;
    localparam logic [15:0] K_J   = 16'h4000;
    localparam logic [15:0] K_FI  = 16'h8000;

    logic        mclk = 1'b0;
    logic        i_reset;
    logic        mclk_en;
    logic [3:0]  i_opcode;
    logic        i_carry_flag;
    logic        i_zero_flag;
    logic [15:0] o_ctrl;
    logic [2:0]  o_step;
    logic        o_halted;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .mclk         (mclk),
        .i_reset      (i_reset),
        .mclk_en      (mclk_en),
        .i_opcode     (i_opcode),
        .i_carry_flag (i_carry_flag),
        .i_zero_flag  (i_zero_flag),
        .o_ctrl       (o_ctrl),
        .o_step       (o_step),
        .o_halted     (o_halted)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [3:0]       op;
        logic             c;
        logic             z;
        int               n;
        logic [4:0][15:0] w;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        i_reset = 1'b1;
        mclk_en = en;
        tick();
        i_reset = 1'b0;
        mclk_en = 1'b1;
    endtask

    // Instruction length in steps, fetch included
    function automatic int op_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Control word for position pos within the instruction
    function automatic logic [15:0] op_word(input logic [3:0] op, input int pos,
                                            input logic c, input logic z);
        if (pos == 0) return K_CO | K_MI;
        if (pos == 1) return K_RO | K_II | K_CE;
        case (op)
            4'h1: return (pos == 2) ? (K_IO | K_MI) : (K_RO | K_AI);
            4'h2: begin
                if (pos == 2) return K_IO | K_MI;
                if (pos == 3) return K_RO | K_BI;
                return K_EO | K_AI | K_FI;
            end
            4'h3: begin
                if (pos == 2) return K_IO | K_MI;
                if (pos == 3) return K_RO | K_BI;
                return K_EO | K_AI | K_FI | K_SU;
            end
            4'h4: return (pos == 2) ? (K_IO | K_MI) : (K_AO | K_RI);
            4'h5: return K_IO | K_AI;
            4'h6: return K_IO | K_J;
            4'h7: return c ? (K_IO | K_J) : 16'h0000;
            4'h8: return z ? (K_IO | K_J) : 16'h0000;
            4'hE: return K_AO | K_OI;
            4'hF: return K_HLT;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic set_vec(input int i, input logic [3:0] op, input logic c,
                           input logic z, input int n, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4);
        vecs[i].op = op;
        vecs[i].c  = c;
        vecs[i].z  = z;
        vecs[i].n  = n;
        vecs[i].w  = {w4, w3, w2, K_RO | K_II | K_CE, K_CO | K_MI};
    endtask

    initial begin
        int pos;
        bit halted;
        logic [3:0] op;
        logic rst;
        int exp_step;

        i_reset      = 1'b1;
        mclk_en      = 1'b1;
        i_opcode     = 4'h0;
        i_carry_flag = 1'b0;
        i_zero_flag  = 1'b0;

        set_vec(0,  4'h0, 0, 0, 3, 16'h0000, 0, 0);
        set_vec(1,  4'h1, 0, 0, 4, K_IO | K_MI, K_RO | K_AI, 0);
        set_vec(2,  4'h2, 0, 0, 5, K_IO | K_MI, K_RO | K_BI, 16'h8140);
        set_vec(3,  4'h3, 1, 1, 5, K_IO | K_MI, K_RO | K_BI, 16'h8340);
        set_vec(4,  4'h4, 0, 0, 4, K_IO | K_MI, K_AO | K_RI, 0);
        set_vec(5,  4'h5, 0, 0, 3, K_IO | K_AI, 0, 0);
        set_vec(6,  4'h6, 0, 0, 3, 16'h4010, 0, 0);
        set_vec(7,  4'h7, 0, 1, 3, 16'h0000, 0, 0);
        set_vec(8,  4'h7, 1, 0, 3, 16'h4010, 0, 0);
        set_vec(9,  4'h8, 1, 0, 3, 16'h0000, 0, 0);
        set_vec(10, 4'h8, 0, 1, 3, 16'h4010, 0, 0);
        set_vec(11, 4'hE, 0, 0, 3, K_AO | K_OI, 0, 0);
        set_vec(12, 4'h9, 1, 1, 3, 16'h0000, 0, 0);
        set_vec(13, 4'hD, 0, 0, 3, 16'h0000, 0, 0);

        // Reset with clock enabled
        tick();
        i_reset = 1'b0;
        chk("reset_step", 16'(o_step), 16'h0000);
        chk("reset_ctrl", o_ctrl, 16'h2002);
        chk("reset_halted", 16'(o_halted), 16'h0000);

        // Vector table: one full instruction each
        foreach (vecs[v]) begin
            do_reset(1'b1);
            i_opcode     = vecs[v].op;
            i_carry_flag = vecs[v].c;
            i_zero_flag  = vecs[v].z;
            for (int s = 0; s < vecs[v].n; s++) begin
                #1;
                chk($sformatf("vec%0d_step%0d", v, s), 16'(o_step), 16'(s));
                chk($sformatf("vec%0d_ctrl%0d", v, s), o_ctrl, vecs[v].w[s]);
                tick();
            end
            chk($sformatf("vec%0d_wrap", v), 16'(o_step), 16'h0000);
        end

        // Enable toggling on ADD: only enabled edges advance
        do_reset(1'b0);
        i_opcode = 4'h2;
        exp_step = 0;
        for (int k = 0; k < 14; k++) begin
            mclk_en = k[0] ? 1'b0 : 1'b1;
            #1;
            chk($sformatf("en_step%0d", k), 16'(o_step), 16'(exp_step));
            chk($sformatf("en_cej%0d", k), 16'(o_ctrl[12] & o_ctrl[14]), 16'h0000);
            tick();
            if (mclk_en) exp_step = (exp_step == 4) ? 0 : exp_step + 1;
        end

        // Halt: freeze at step 2 for 20 clocks
        do_reset(1'b1);
        i_opcode = 4'hF;
        tick();
        tick();
        chk("hlt_t2_ctrl", o_ctrl, 16'h0001);
        chk("hlt_t2_halted", 16'(o_halted), 16'h0000);
        tick();
        for (int k = 0; k < 20; k++) begin
            mclk_en  = 1'($urandom_range(0, 1));
            i_opcode = 4'($urandom_range(0, 15));
            #1;
            chk($sformatf("hlt_step%0d", k), 16'(o_step), 16'h0002);
            chk($sformatf("hlt_ctrl%0d", k), o_ctrl, 16'h0001);
            chk($sformatf("hlt_flag%0d", k), 16'(o_halted), 16'h0001);
            tick();
        end

        // Reset during halt with clock disabled
        do_reset(1'b0);
        chk("rst_halt_step", 16'(o_step), 16'h0000);
        chk("rst_halt_flag", 16'(o_halted), 16'h0000);
        chk("rst_halt_ctrl", o_ctrl, 16'h2002);

        // Reset during ADD T3
        i_opcode = 4'h2;
        tick();
        tick();
        tick();
        chk("add_t3_step", 16'(o_step), 16'h0003);
        do_reset(1'b1);
        chk("rst_add_step", 16'(o_step), 16'h0000);
        chk("rst_add_flag", 16'(o_halted), 16'h0000);
        chk("rst_add_ctrl", o_ctrl, 16'h2002);

        // Random run against the instruction-level model
        do_reset(1'b1);
        pos    = 0;
        halted = 0;
        op     = 4'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (pos == 0 && !halted) begin
                op = ($urandom_range(0, 19) == 0) ? 4'hF
                                                  : 4'($urandom_range(0, 14));
            end
            i_reset      = rst;
            mclk_en      = ($urandom_range(0, 3) != 0);
            i_opcode     = op;
            i_carry_flag = 1'($urandom_range(0, 1));
            i_zero_flag  = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_step", 16'(o_step), 16'(pos));
            chk("rnd_halted", 16'(o_halted), 16'(halted));
            chk("rnd_ctrl", o_ctrl, halted ? K_HLT
                : op_word(op, pos, i_carry_flag, i_zero_flag));
            chk("rnd_cej", 16'(o_ctrl[12] & o_ctrl[14]), 16'h0000);
            tick();
            if (rst) begin
                pos    = 0;
                halted = 0;
            end else if (mclk_en && !halted) begin
                if (op == 4'hF && pos == 2) halted = 1;
                else if (pos == op_len(op) - 1) pos = 0;
                else pos++;
            end
        end
        i_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
